// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: user-interface arbiter states and timing constants.
package psram_pkg;

    localparam int AXI4_DATA_WIDTH = 32;
    localparam int DRAIN_CYCLES    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-way round-robin pick: one-hot grant plus the pointer value to store on a win.
module psram_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_q,
    output logic [1:0] gnt,
    output logic       rr_nxt
);

    // The loser of a win becomes the favoured port for the next contention.
    always_comb begin
        gnt    = 2'b00;
        rr_nxt = rr_q;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                rr_nxt = 1'b1;
            end
            2'b10: begin
                gnt    = 2'b10;
                rr_nxt = 1'b0;
            end
            2'b11: begin
                if (rr_q) begin
                    gnt    = 2'b10;
                    rr_nxt = 1'b0;
                end else begin
                    gnt    = 2'b01;
                    rr_nxt = 1'b1;
                end
            end
            default: begin
                gnt    = 2'b00;
                rr_nxt = rr_q;
            end
        endcase
    end

endmodule

// File: rtl/psram_usr_arb.sv
// Shares the PSRAM user interface between two requesters; a grant owns the
// interface for a whole burst, followed by one idle cycle for CE recovery.
module psram_usr_arb
    import psram_pkg::*;
#(
    parameter int USR_ADDR_WIDTH = 23,
    parameter int DATA_WIDTH     = AXI4_DATA_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      req0_req_i,
    output logic                      req0_gnt_o,
    input  logic                      req0_xfer_start_i,
    input  logic                      req0_wen_i,
    input  logic [7:0]                req0_wlen_i,
    input  logic [USR_ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   req0_bm_i,
    input  logic [DATA_WIDTH-1:0]     req0_dat_i,
    output logic [DATA_WIDTH-1:0]     req0_dat_o,
    output logic                      req0_wready_o,
    output logic                      req0_rvalid_o,
    input  logic                      req1_req_i,
    output logic                      req1_gnt_o,
    input  logic                      req1_xfer_start_i,
    input  logic                      req1_wen_i,
    input  logic [7:0]                req1_wlen_i,
    input  logic [USR_ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   req1_bm_i,
    input  logic [DATA_WIDTH-1:0]     req1_dat_i,
    output logic [DATA_WIDTH-1:0]     req1_dat_o,
    output logic                      req1_wready_o,
    output logic                      req1_rvalid_o,
    output logic                      usr_xfer_start_o,
    output logic                      usr_wen_o,
    output logic [7:0]                usr_wlen_o,
    output logic [USR_ADDR_WIDTH-1:0] usr_addr_o,
    output logic [DATA_WIDTH/8-1:0]   usr_bm_o,
    output logic [DATA_WIDTH-1:0]     usr_dat_o,
    input  logic [DATA_WIDTH-1:0]     usr_dat_i,
    input  logic                      usr_wready_i,
    input  logic                      usr_rvalid_i,
    output logic                      busy_o
);

    arb_state_t state_q, state_d;
    logic       rr_q, rr_d;
    logic [7:0] len_q, len_d;
    logic [8:0] beat_cnt_q, beat_cnt_d;
    logic       busy_q, busy_d;
    logic [1:0] arb_gnt_s;
    logic       arb_rr_nxt_s;
    logic       beat_s;
    logic       idle_s;

    psram_rr_arb2 u_rr_arb2 (
        .req    ({req1_req_i, req0_req_i}),
        .rr_q   (rr_q),
        .gnt    (arb_gnt_s),
        .rr_nxt (arb_rr_nxt_s)
    );

    assign idle_s     = (state_q == IDLE);
    assign beat_s     = usr_wready_i | usr_rvalid_i;
    assign req0_gnt_o = idle_s & arb_gnt_s[0];
    assign req1_gnt_o = idle_s & arb_gnt_s[1];
    assign busy_o     = busy_q;
    assign req0_dat_o = usr_dat_i;
    assign req1_dat_o = usr_dat_i;

    // Ownership FSM; the 9-bit beat counter lets a 256-beat burst finish without wrapping.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_gnt_s[0]) begin
                    state_d    = OWN0;
                    len_d      = req0_wlen_i;
                    beat_cnt_d = 9'd0;
                    rr_d       = arb_rr_nxt_s;
                end else if (arb_gnt_s[1]) begin
                    state_d    = OWN1;
                    len_d      = req1_wlen_i;
                    beat_cnt_d = 9'd0;
                    rr_d       = arb_rr_nxt_s;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (beat_cnt_q == {1'b0, len_q}) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == OWN0) || (state_d == OWN1);
    end

    // State registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            len_q      <= 8'd0;
            beat_cnt_q <= 9'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Downstream mux and handshake gating; everything is quiet without an owner.
    always_comb begin
        usr_xfer_start_o = 1'b0;
        usr_wen_o        = 1'b0;
        usr_wlen_o       = 8'd0;
        usr_addr_o       = {USR_ADDR_WIDTH{1'b0}};
        usr_bm_o         = {(DATA_WIDTH/8){1'b0}};
        usr_dat_o        = {DATA_WIDTH{1'b0}};
        req0_wready_o    = 1'b0;
        req0_rvalid_o    = 1'b0;
        req1_wready_o    = 1'b0;
        req1_rvalid_o    = 1'b0;
        case (state_q)
            OWN0: begin
                usr_xfer_start_o = req0_xfer_start_i;
                usr_wen_o        = req0_wen_i;
                usr_wlen_o       = req0_wlen_i;
                usr_addr_o       = req0_addr_i;
                usr_bm_o         = req0_bm_i;
                usr_dat_o        = req0_dat_i;
                req0_wready_o    = usr_wready_i;
                req0_rvalid_o    = usr_rvalid_i;
            end
            OWN1: begin
                usr_xfer_start_o = req1_xfer_start_i;
                usr_wen_o        = req1_wen_i;
                usr_wlen_o       = req1_wlen_i;
                usr_addr_o       = req1_addr_i;
                usr_bm_o         = req1_bm_i;
                usr_dat_o        = req1_dat_i;
                req1_wready_o    = usr_wready_i;
                req1_rvalid_o    = usr_rvalid_i;
            end
            default: begin
                usr_xfer_start_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_psram_usr_arb.sv
// Bench for psram_usr_arb: directed scenarios plus random traffic, all checked
// every cycle against a burst-level model (owner, beats remaining, drain flag).
module tb_psram_usr_arb;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int UW = 2 + 8 + AW + BW + DW;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic          req0_req_i, req0_gnt_o, req0_xfer_start_i, req0_wen_i;
    logic [7:0]    req0_wlen_i;
    logic [AW-1:0] req0_addr_i;
    logic [BW-1:0] req0_bm_i;
    logic [DW-1:0] req0_dat_i, req0_dat_o;
    logic          req0_wready_o, req0_rvalid_o;
    logic          req1_req_i, req1_gnt_o, req1_xfer_start_i, req1_wen_i;
    logic [7:0]    req1_wlen_i;
    logic [AW-1:0] req1_addr_i;
    logic [BW-1:0] req1_bm_i;
    logic [DW-1:0] req1_dat_i, req1_dat_o;
    logic          req1_wready_o, req1_rvalid_o;
    logic          usr_xfer_start_o, usr_wen_o;
    logic [7:0]    usr_wlen_o;
    logic [AW-1:0] usr_addr_o;
    logic [BW-1:0] usr_bm_o;
    logic [DW-1:0] usr_dat_o, usr_dat_i;
    logic          usr_wready_i, usr_rvalid_i, busy_o;

    psram_usr_arb #(.USR_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req0_req_i(req0_req_i), .req0_gnt_o(req0_gnt_o),
        .req0_xfer_start_i(req0_xfer_start_i), .req0_wen_i(req0_wen_i),
        .req0_wlen_i(req0_wlen_i), .req0_addr_i(req0_addr_i), .req0_bm_i(req0_bm_i),
        .req0_dat_i(req0_dat_i), .req0_dat_o(req0_dat_o),
        .req0_wready_o(req0_wready_o), .req0_rvalid_o(req0_rvalid_o),
        .req1_req_i(req1_req_i), .req1_gnt_o(req1_gnt_o),
        .req1_xfer_start_i(req1_xfer_start_i), .req1_wen_i(req1_wen_i),
        .req1_wlen_i(req1_wlen_i), .req1_addr_i(req1_addr_i), .req1_bm_i(req1_bm_i),
        .req1_dat_i(req1_dat_i), .req1_dat_o(req1_dat_o),
        .req1_wready_o(req1_wready_o), .req1_rvalid_o(req1_rvalid_o),
        .usr_xfer_start_o(usr_xfer_start_o), .usr_wen_o(usr_wen_o),
        .usr_wlen_o(usr_wlen_o), .usr_addr_o(usr_addr_o), .usr_bm_o(usr_bm_o),
        .usr_dat_o(usr_dat_o), .usr_dat_i(usr_dat_i),
        .usr_wready_i(usr_wready_i), .usr_rvalid_i(usr_rvalid_i), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who owns the bus, beats still owed, post-burst gap.
    int  m_owner;
    int  m_left;
    int  m_rr;
    bit  m_drain;
    bit  e_gnt0, e_gnt1;

    logic [6:0]    s_ctl;
    logic [7:0]    s_wlen;
    logic [UW-1:0] s_usr;
    int cyc;
    int gnt_log[$];
    int gnt_cyc[$];
    int rv0_cnt, rv1_cnt;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic randomize_payload();
        req0_xfer_start_i = 1'($urandom);
        req0_wen_i        = 1'($urandom);
        req0_addr_i       = AW'($urandom);
        req0_bm_i         = BW'($urandom);
        req0_dat_i        = $urandom;
        req1_xfer_start_i = 1'($urandom);
        req1_wen_i        = 1'($urandom);
        req1_addr_i       = AW'($urandom);
        req1_bm_i         = BW'($urandom);
        req1_dat_i        = $urandom;
        usr_dat_i         = $urandom;
    endtask

    // One clock: called at posedge+1 with inputs set; checks mid-cycle, updates model at the edge.
    task automatic tick();
        logic [6:0]    e_ctl;
        logic [UW-1:0] e_usr;
        bit            idle;
        randomize_payload();
        #3;
        if (!aresetn) begin
            m_owner = -1; m_left = 0; m_rr = 0; m_drain = 1'b0;
        end
        idle   = (m_owner < 0) && !m_drain;
        e_gnt0 = idle && req0_req_i && (!req1_req_i || m_rr == 0);
        e_gnt1 = idle && req1_req_i && (!req0_req_i || m_rr == 1);
        e_ctl  = {e_gnt0, e_gnt1, (m_owner >= 0),
                  (m_owner == 0) && usr_wready_i, (m_owner == 1) && usr_wready_i,
                  (m_owner == 0) && usr_rvalid_i, (m_owner == 1) && usr_rvalid_i};
        if (m_owner == 0)
            e_usr = {req0_xfer_start_i, req0_wen_i, req0_wlen_i, req0_addr_i, req0_bm_i, req0_dat_i};
        else if (m_owner == 1)
            e_usr = {req1_xfer_start_i, req1_wen_i, req1_wlen_i, req1_addr_i, req1_bm_i, req1_dat_i};
        else
            e_usr = '0;
        s_ctl  = {req0_gnt_o, req1_gnt_o, busy_o, req0_wready_o, req1_wready_o,
                  req0_rvalid_o, req1_rvalid_o};
        s_wlen = usr_wlen_o;
        s_usr  = {usr_xfer_start_o, usr_wen_o, usr_wlen_o, usr_addr_o, usr_bm_o, usr_dat_o};
        check_eq("ctl", s_ctl, e_ctl);
        check_eq("usr", s_usr, e_usr);
        check_eq("rdat", {req0_dat_o, req1_dat_o}, {usr_dat_i, usr_dat_i});
        if (req0_gnt_o) begin gnt_log.push_back(0); gnt_cyc.push_back(cyc); end
        if (req1_gnt_o) begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
        if (req0_rvalid_o) rv0_cnt++;
        if (req1_rvalid_o) rv1_cnt++;
        @(posedge aclk);
        if (aresetn) begin
            if (e_gnt0) begin
                m_owner = 0; m_left = int'(req0_wlen_i) + 1; m_rr = 1;
            end else if (e_gnt1) begin
                m_owner = 1; m_left = int'(req1_wlen_i) + 1; m_rr = 0;
            end else if (m_owner >= 0) begin
                if (usr_wready_i || usr_rvalid_i) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_owner = -1; m_drain = 1'b1;
                    end
                end
            end else begin
                m_drain = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        req0_req_i = 1'b0; req1_req_i = 1'b0;
        usr_wready_i = 1'b0; usr_rvalid_i = 1'b0;
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        int b;
        cyc = 0; rv0_cnt = 0; rv1_cnt = 0;
        m_owner = -1; m_left = 0; m_rr = 0; m_drain = 1'b0;
        aresetn = 1'b0;
        req0_req_i = 1'b0; req1_req_i = 1'b0;
        req0_wlen_i = 8'd0; req1_wlen_i = 8'd0;
        usr_wready_i = 1'b0; usr_rvalid_i = 1'b0;
        randomize_payload();
        @(posedge aclk); #1;
        do_reset();
        check_eq("reset_outs", {s_ctl, s_usr}, '0);

        // Port 0 write, len 3, four beats.
        req0_req_i = 1'b1; req0_wlen_i = 8'd3;
        tick();
        check_eq("t1_gnt0", s_ctl[6], 1'b1);
        req0_req_i = 1'b0; usr_wready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t1_wlen", s_wlen, 8'd3);
            check_eq("t1_busy", s_ctl[4], 1'b1);
            check_eq("t1_no_wr1", s_ctl[2], 1'b0);
        end
        usr_wready_i = 1'b0;
        tick();
        check_eq("t1_drain", s_ctl[4], 1'b0);
        tick();

        // Simultaneous requests after reset: port 0 first, port 1 follows the drain.
        do_reset();
        req0_req_i = 1'b1; req1_req_i = 1'b1;
        req0_wlen_i = 8'd0; req1_wlen_i = 8'd0;
        tick();
        check_eq("t2_gnt_first", s_ctl[6:5], 2'b10);
        req0_req_i = 1'b0; usr_wready_i = 1'b1;
        b = cyc;
        tick();
        usr_wready_i = 1'b0;
        tick();
        check_eq("t2_no_gnt_drain", s_ctl[5], 1'b0);
        tick();
        check_eq("t2_gnt1", s_ctl[5], 1'b1);
        check_eq("t2_gnt1_lat", cyc - 1 - b, 2);
        req1_req_i = 1'b0; usr_wready_i = 1'b1;
        tick();
        check_eq("t2_own1_beat_plus3", s_ctl[4] & s_ctl[2], 1'b1);
        usr_wready_i = 1'b0;
        tick(); tick();

        // Continuous contention, single-beat bursts.
        do_reset();
        gnt_log.delete(); gnt_cyc.delete();
        req0_req_i = 1'b1; req1_req_i = 1'b1; usr_wready_i = 1'b1;
        for (int i = 0; i < 24; i++) tick();
        req0_req_i = 1'b0; req1_req_i = 1'b0; usr_wready_i = 1'b0;
        tick(); tick();
        check_eq("t3_n_gnt", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            check_eq("t3_order", gnt_log[i], i % 2);

        // Port 1 read, 256 beats.
        req1_req_i = 1'b1; req1_wlen_i = 8'd255;
        tick();
        check_eq("t4_gnt1", s_ctl[5], 1'b1);
        req1_req_i = 1'b0; usr_rvalid_i = 1'b1;
        rv0_cnt = 0; rv1_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 255) check_eq("t4_busy_last", s_ctl[4], 1'b1);
        end
        usr_rvalid_i = 1'b0;
        tick();
        check_eq("t4_released", s_ctl[4], 1'b0);
        check_eq("t4_rv1_cnt", rv1_cnt, 256);
        check_eq("t4_rv0_cnt", rv0_cnt, 0);
        tick();

        // Reset in the middle of an 8-beat port 1 burst.
        req1_req_i = 1'b1; req1_wlen_i = 8'd7;
        tick();
        req1_req_i = 1'b0; usr_wready_i = 1'b1;
        tick(); tick();
        aresetn = 1'b0;
        tick();
        check_eq("t5_rst_zero", {s_ctl, s_usr}, '0);
        usr_wready_i = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        req0_req_i = 1'b1; req0_wlen_i = 8'd0;
        tick();
        check_eq("t5_gnt0", s_ctl[6], 1'b1);
        req0_req_i = 1'b0; usr_wready_i = 1'b1;
        tick();
        check_eq("t5_own0", s_ctl[4], 1'b1);
        usr_wready_i = 1'b0;
        tick(); tick();

        // Spurious beat while idle.
        usr_wready_i = 1'b1;
        tick();
        check_eq("t6_no_fwd", s_ctl, 7'd0);
        usr_wready_i = 1'b0;
        tick();
        check_eq("t6_idle", s_ctl[4], 1'b0);
        req0_req_i = 1'b1;
        tick();
        check_eq("t6_gnt0", s_ctl[6], 1'b1);
        req0_req_i = 1'b0; usr_wready_i = 1'b1;
        tick();
        usr_wready_i = 1'b0;
        tick(); tick();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (e_gnt0) req0_req_i = 1'b0;
            else if (req0_req_i && $urandom_range(0, 15) == 0) req0_req_i = 1'b0;
            else if (!req0_req_i && $urandom_range(0, 3) == 0) begin
                req0_req_i  = 1'b1;
                req0_wlen_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
            end
            if (e_gnt1) req1_req_i = 1'b0;
            else if (req1_req_i && $urandom_range(0, 15) == 0) req1_req_i = 1'b0;
            else if (!req1_req_i && $urandom_range(0, 3) == 0) begin
                req1_req_i  = 1'b1;
                req1_wlen_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
            end
            usr_wready_i = ($urandom_range(0, 2) == 0);
            usr_rvalid_i = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
